uart_tx_arbiter: RTL and testbench

- Shares the single UART transmit byte stream (tvalid/tready/tdata) between NUM_REQ independent byte producers, e.g. the ADC sample dumper and a status/command-echo source.
- Arbitrates per packet: a granted requester keeps the link until it presents tlast. Packets never interleave, so ASCII lines stay intact.
- Sits between the requesters and the uart transmitter. A lock timeout recovers from a stalled producer.

---
 rtl/uart_arb_pkg.sv | 8 +
 rtl/rr_pick.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 125 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter and related shared-resource controllers.
package uart_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  localparam int MAX_REQ = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after last_i, with wrap-around.
module rr_pick #(
  parameter  int NUM_REQ = 2,
  localparam int W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [W-1:0]       last_i,
  output logic [W-1:0]       winner_o,
  output logic               found_o
);

  logic [W-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest hit is assigned last.
  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    idx      = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = W'((int'(last_i) + i) % NUM_REQ);
      if (req_i[idx]) begin
        found_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART tx byte stream among NUM_REQ producers,
// with a single-entry output register and an idle-lock timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_tvalid,
  output logic [NUM_REQ-1:0]           req_tready,
  input  logic [8*NUM_REQ-1:0]         req_tdata,
  input  logic [NUM_REQ-1:0]           req_tlast,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [7:0]                   m_tdata,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic                         timeout_pulse
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t                 state_q;
  logic [GW-1:0]              grant_q, last_grant_q;
  logic                       busy_q, to_pulse_q;
  logic [CW-1:0]              cnt_q;
  logic                       mvld_q, mvld_d;
  logic [7:0]                 mdata_q, mdata_d;

  logic [NUM_REQ-1:0][7:0]    req_data_a;
  logic [GW-1:0]              winner;
  logic                       found;
  logic                       locked, ready_int, own_vld, own_last, accept, to_hit;

  assign req_data_a = req_tdata;
  assign locked     = (state_q == ARB_LOCKED);
  assign ready_int  = !mvld_q || m_tready;
  assign own_vld    = req_tvalid[grant_q];
  assign own_last   = req_tlast[grant_q];
  assign accept     = locked && own_vld && ready_int;
  assign to_hit     = (TIMEOUT_CYCLES != 0) && locked && !own_vld && (cnt_q == TO_LAST);

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i    (req_tvalid),
    .last_i   (last_grant_q),
    .winner_o (winner),
    .found_o  (found)
  );

  always_comb begin
    req_tready          = '0;
    req_tready[grant_q] = locked && ready_int;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      busy_q       <= 1'b0;
      to_pulse_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      to_pulse_q <= 1'b0;
      case (state_q)
        ARB_IDLE: if (found) begin
          grant_q      <= winner;
          last_grant_q <= winner;
          busy_q       <= 1'b1;
          cnt_q        <= '0;
          state_q      <= ARB_LOCKED;
        end
        ARB_LOCKED: begin
          if (accept) begin
            cnt_q <= '0;
            if (own_last) begin
              state_q <= ARB_IDLE;
              busy_q  <= 1'b0;
            end
          end else if (to_hit) begin
            // Stalled producer: drop the lock; the partial packet is simply truncated.
            state_q    <= ARB_IDLE;
            busy_q     <= 1'b0;
            to_pulse_q <= 1'b1;
          end else if (!own_vld && TIMEOUT_CYCLES != 0) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    mvld_d  = mvld_q;
    mdata_d = mdata_q;
    if (accept) begin
      mvld_d  = 1'b1;
      mdata_d = req_data_a[grant_q];
    end else if (m_tready) begin
      mvld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mvld_q  <= 1'b0;
      mdata_q <= '0;
    end else begin
      mvld_q  <= mvld_d;
      mdata_q <= mdata_d;
    end
  end

  assign m_tvalid      = mvld_q;
  assign m_tdata       = mdata_q;
  assign grant_id      = grant_q;
  assign busy          = busy_q;
  assign timeout_pulse = to_pulse_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle vector table, hand-written corner sequences and
// randomized packet streams checked against a packet-order reference model.
module tb_uart_tx_arbiter;

  localparam int NR = 2;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_tvalid, req_tready, req_tlast;
  logic [8*NR-1:0] req_tdata;
  logic            m_tvalid, m_tready;
  logic [7:0]      m_tdata;
  logic [0:0]      grant_id;
  logic            busy, timeout_pulse;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_tvalid    (req_tvalid),
    .req_tready    (req_tready),
    .req_tdata     (req_tdata),
    .req_tlast     (req_tlast),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .m_tdata       (m_tdata),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_tvalid = '0;
    req_tlast  = '0;
    req_tdata  = '0;
    m_tready   = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset outputs", 32'({m_tvalid, m_tdata, busy, grant_id, timeout_pulse, req_tready}), 32'(0));
    rst = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rb;
    logic [1:0] vld;
    logic [7:0] d0, d1;
    logic [1:0] last;
    logic       mrdy;
    logic       emv;
    logic [7:0] emd;
    logic       ebusy;
    logic       egid;
    logic [1:0] etr;
  } vec_t;

  vec_t tbl[14];

  // ---------------- stream engine ----------------
  logic [8:0] pbuf [NR][128];
  int         ph [NR];
  int         pt [NR];
  int         gap[NR];
  logic [7:0] exp_q[$];

  task automatic clear_pkts();
    for (int r = 0; r < NR; r++) begin
      ph[r] = 0; pt[r] = 0; gap[r] = 0;
    end
    exp_q.delete();
  endtask

  task automatic add_pkt(input int r, input int len, input bit rnd, input int base);
    for (int i = 0; i < len; i++) begin
      pbuf[r][pt[r]] = {(i == len - 1), (rnd ? 8'($urandom) : 8'(base + i))};
      pt[r]++;
    end
  endtask

  // Every requester sits ready at each packet start, so the link serves whole packets
  // alternating over requesters that still have data, starting at requester 0.
  task automatic build_exp();
    int rp[NR];
    bit more;
    for (int r = 0; r < NR; r++) rp[r] = 0;
    do begin
      more = 1'b0;
      for (int r = 0; r < NR; r++) begin
        if (rp[r] < pt[r]) begin
          more = 1'b1;
          do begin
            exp_q.push_back(pbuf[r][rp[r]][7:0]);
            rp[r]++;
          end while (!pbuf[r][rp[r]-1][8]);
        end
      end
    end while (more);
  endtask

  task automatic run_stream(input bit rnd, input int stall_lo, input int stall_hi);
    int rx    = 0;
    int cyc_n = 0;
    int n_exp = exp_q.size();
    bit to_seen = 1'b0;
    while (rx < n_exp && cyc_n < 2000) begin
      @(negedge clk);
      for (int r = 0; r < NR; r++) begin
        if (gap[r] > 0) begin
          req_tvalid[r] = 1'b0;
          gap[r]--;
        end else begin
          req_tvalid[r] = (ph[r] != pt[r]);
        end
        req_tdata[8*r +: 8] = pbuf[r][ph[r]][7:0];
        req_tlast[r]        = pbuf[r][ph[r]][8];
      end
      m_tready = rnd ? ($urandom_range(3) != 0) : !(cyc_n >= stall_lo && cyc_n <= stall_hi);
      #1;
      if (m_tvalid) check($sformatf("stream byte %0d", rx), 32'(m_tdata), 32'(exp_q[rx]));
      if (m_tvalid && !m_tready) check("accept under stall", 32'(req_tready), 32'(0));
      if (timeout_pulse) to_seen = 1'b1;
      if (m_tvalid && m_tready) rx++;
      for (int r = 0; r < NR; r++) begin
        if (req_tvalid[r] && req_tready[r]) begin
          if (rnd && !pbuf[r][ph[r]][8]) gap[r] = $urandom_range(3);
          ph[r]++;
        end
      end
      cyc_n++;
    end
    check("stream bytes received", 32'(rx), 32'(n_exp));
    check("stream no timeout", 32'(to_seen), 32'(0));
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulse_k;
    int n;
    bit prev;

    idle_inputs();
    #2;

    // single requester "3F\n", then two-way contention A1,A2 / B1,B2
    tbl[0]  = '{1'b1, 2'b01, 8'h33, 8'h00, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00};
    tbl[1]  = '{1'b0, 2'b01, 8'h33, 8'h00, 2'b00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'b01};
    tbl[2]  = '{1'b0, 2'b01, 8'h46, 8'h00, 2'b00, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 2'b01};
    tbl[3]  = '{1'b0, 2'b01, 8'h0A, 8'h00, 2'b01, 1'b1, 1'b1, 8'h46, 1'b1, 1'b0, 2'b01};
    tbl[4]  = '{1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 1'b1, 8'h0A, 1'b0, 1'b0, 2'b00};
    tbl[5]  = '{1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00};
    tbl[6]  = '{1'b1, 2'b11, 8'hA1, 8'hB1, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00};
    tbl[7]  = '{1'b0, 2'b11, 8'hA1, 8'hB1, 2'b00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'b01};
    tbl[8]  = '{1'b0, 2'b11, 8'hA2, 8'hB1, 2'b01, 1'b1, 1'b1, 8'hA1, 1'b1, 1'b0, 2'b01};
    tbl[9]  = '{1'b0, 2'b10, 8'h00, 8'hB1, 2'b00, 1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 2'b00};
    tbl[10] = '{1'b0, 2'b10, 8'h00, 8'hB1, 2'b00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'b10};
    tbl[11] = '{1'b0, 2'b10, 8'h00, 8'hB2, 2'b10, 1'b1, 1'b1, 8'hB1, 1'b1, 1'b1, 2'b10};
    tbl[12] = '{1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 1'b1, 8'hB2, 1'b0, 1'b1, 2'b00};
    tbl[13] = '{1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00};

    foreach (tbl[i]) begin
      if (tbl[i].rb) do_reset();
      @(negedge clk);
      req_tvalid = tbl[i].vld;
      req_tdata  = {tbl[i].d1, tbl[i].d0};
      req_tlast  = tbl[i].last;
      m_tready   = tbl[i].mrdy;
      #1;
      check($sformatf("row%0d m_tvalid", i), 32'(m_tvalid), 32'(tbl[i].emv));
      if (tbl[i].emv) check($sformatf("row%0d m_tdata", i), 32'(m_tdata), 32'(tbl[i].emd));
      check($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].ebusy));
      check($sformatf("row%0d grant_id", i), 32'(grant_id), 32'(tbl[i].egid));
      check($sformatf("row%0d req_tready", i), 32'(req_tready), 32'(tbl[i].etr));
      check($sformatf("row%0d timeout_pulse", i), 32'(timeout_pulse), 32'(0));
    end

    // fairness: both always valid with single-byte packets
    do_reset();
    req_tvalid = 2'b11;
    req_tdata  = {8'h20, 8'h10};
    req_tlast  = 2'b11;
    prev = 1'b0;
    n    = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      @(negedge clk);
      #1;
      if (busy && !prev) begin
        check($sformatf("fair grant %0d", n), 32'(grant_id), 32'(n % 2));
        n++;
      end
      prev = busy;
    end
    check("fair grant count", 32'(n), 32'(8));
    idle_inputs();

    // backpressure: consumer stalls for 5 cycles in the middle of a 6-byte packet
    do_reset();
    clear_pkts();
    add_pkt(0, 6, 1'b0, 8'h51);
    build_exp();
    run_stream(1'b0, 4, 8);

    // timeout: req0 sends one byte without tlast then goes silent, req1 waits
    do_reset();
    @(negedge clk);
    req_tvalid = 2'b01;
    req_tdata  = {8'h00, 8'h77};
    req_tlast  = 2'b00;
    @(negedge clk);
    @(negedge clk);
    req_tvalid = 2'b10;
    req_tdata  = {8'h88, 8'h00};
    req_tlast  = 2'b10;
    #1;
    check("to byte out", 32'({m_tvalid, m_tdata}), 32'({1'b1, 8'h77}));
    pulse_k = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) begin
        @(negedge clk);
        #1;
      end
      if (timeout_pulse) begin
        pulse_k = k;
        break;
      end
      if (!busy) begin
        check("to busy held", 32'(busy), 32'(1));
        break;
      end
    end
    check("to idle edges before pulse", 32'(pulse_k - 1), 32'(TO));
    check("to busy at pulse", 32'(busy), 32'(0));
    @(negedge clk);
    #1;
    check("to pulse width", 32'(timeout_pulse), 32'(0));
    check("to regrant busy", 32'(busy), 32'(1));
    check("to regrant id", 32'(grant_id), 32'(1));
    check("to regrant tready", 32'(req_tready), 32'(2'b10));
    @(negedge clk);
    req_tvalid = 2'b00;
    #1;
    check("to req1 byte", 32'({m_tvalid, m_tdata}), 32'({1'b1, 8'h88}));
    idle_inputs();

    // asynchronous reset in the middle of a stalled req1 packet
    do_reset();
    @(negedge clk);
    req_tvalid = 2'b10;
    req_tdata  = {8'hC1, 8'h00};
    req_tlast  = 2'b00;
    m_tready   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid pkt before reset", 32'({m_tvalid, m_tdata, busy, grant_id}), 32'({1'b1, 8'hC1, 1'b1, 1'b1}));
    #1;
    rst = 1'b0;
    #1;
    check("async reset outputs", 32'({m_tvalid, m_tdata, busy, grant_id, timeout_pulse, req_tready}), 32'(0));
    req_tdata = {8'h99, 8'h00};
    req_tlast = 2'b10;
    m_tready  = 1'b1;
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("post reset grant", 32'({busy, grant_id, req_tready}), 32'({1'b1, 1'b1, 2'b10}));
    @(negedge clk);
    req_tvalid = 2'b00;
    #1;
    check("post reset byte", 32'({m_tvalid, m_tdata, busy}), 32'({1'b1, 8'h99, 1'b0}));
    idle_inputs();

    // randomized packet streams with producer gaps and consumer backpressure
    for (int it = 0; it < 3; it++) begin
      do_reset();
      clear_pkts();
      for (int p = 0; p < 6; p++) add_pkt(0, $urandom_range(5, 1), 1'b1, 0);
      for (int p = 0; p < 8; p++) add_pkt(1, $urandom_range(5, 1), 1'b1, 0);
      build_exp();
      run_stream(1'b1, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
